int_disp_queue: RTL and testbench

- In-order dispatch queue between rename/dispatch and the integer execution block.
- Accepts up to ENQ_NUM renamed integer uops per cycle.
- Presents the oldest DEQ_NUM entries to the integer block, which returns an in-order acceptance mask.
- A squash flushes the whole queue.

---
 rtl/int_disp_queue_pkg.sv | 28 ++
 rtl/int_disp_queue_if.sv | 28 ++
 rtl/int_disp_queue_lead_one_cnt.sv | 23 ++
 rtl/int_disp_queue.sv | 104 ++++++++++
 tb/tb_int_disp_queue.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/int_disp_queue_pkg.sv
// Shared integer-dispatch-queue types and sizing constants.
// Also holds count_one, the popcount used on the enqueue mask.
package int_disp_queue_pkg;

    typedef struct packed {
        logic [31:0] pc_ofs;
        logic [63:0] imm;
        logic [7:0]  psrc1;
        logic [7:0]  psrc2;
        logic [7:0]  pdst;
        logic [7:0]  uop;
    } intDQEntry_t;

    localparam int INTDQ_DEPTH               = 16;
    localparam int INTDQ_ENQ_NUM             = 4;
    localparam int DISP_TO_INT_BLOCK_PORTNUM = 4;
    localparam int INTDQ_ENTRY_W             = $bits(intDQEntry_t);

    function automatic logic [5:0] count_one(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/int_disp_queue_if.sv
// Enqueue/dispatch/squash bundle between rename, the dispatch queue and the integer block.
interface int_disp_queue_if
    import int_disp_queue_pkg::*;
#(
    parameter int DEPTH   = INTDQ_DEPTH,
    parameter int ENQ_NUM = INTDQ_ENQ_NUM,
    parameter int DEQ_NUM = DISP_TO_INT_BLOCK_PORTNUM,
    parameter int ENTRY_W = INTDQ_ENTRY_W
);
    logic                              i_squash_vld;
    logic                              o_can_enq;
    logic [ENQ_NUM-1:0]                i_enq_vld;
    logic [ENQ_NUM-1:0][ENTRY_W-1:0]   i_enq_data;
    logic [DEQ_NUM-1:0]                o_deq_vld;
    logic [DEQ_NUM-1:0][ENTRY_W-1:0]   o_deq_data;
    logic [DEQ_NUM-1:0]                i_deq_accept;
    logic [$clog2(DEPTH+1)-1:0]        o_count;

    modport slave (
        input  i_squash_vld, i_enq_vld, i_enq_data, i_deq_accept,
        output o_can_enq, o_deq_vld, o_deq_data, o_count
    );

    modport master (
        output i_squash_vld, i_enq_vld, i_enq_data, i_deq_accept,
        input  o_can_enq, o_deq_vld, o_deq_data, o_count
    );
endinterface

// File: rtl/int_disp_queue_lead_one_cnt.sv
// Counts consecutive ones starting at bit 0 (stops at the first zero).
module lead_one_cnt #(
    parameter int N  = 4,
    parameter int CW = $clog2(N+1)
) (
    input  logic [N-1:0]  vec_i,
    output logic [CW-1:0] cnt_o
);
    logic [N-1:0] run;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_run
            assign run[gi] = &vec_i[gi:0];
        end
    endgenerate

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < N; i++) begin
            cnt_o = cnt_o + CW'(run[i]);
        end
    end
endmodule

// File: rtl/int_disp_queue.sv
// In-order integer dispatch queue: multi-wide enqueue, oldest-first multi-wide dispatch,
// whole-queue squash. Every output is a function of registered state only.
module int_disp_queue
    import int_disp_queue_pkg::*;
#(
    parameter int DEPTH   = INTDQ_DEPTH,
    parameter int ENQ_NUM = INTDQ_ENQ_NUM,
    parameter int DEQ_NUM = DISP_TO_INT_BLOCK_PORTNUM,
    parameter int ENTRY_W = INTDQ_ENTRY_W
) (
    input  logic              clk,
    input  logic              rst,
    int_disp_queue_if.slave   dq
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int DCNT_W = $clog2(DEQ_NUM+1);

    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic               can_enq, enq_fire;
    logic [CNT_W-1:0]   n_enq, n_deq;
    logic [DEQ_NUM-1:0] deq_vld, acc_masked;
    logic [DCNT_W-1:0]  lead_cnt;

    // Credit check ignores same-cycle dequeues so o_can_enq stays register-only.
    assign can_enq  = (DEPTH - int'(count_q)) >= ENQ_NUM;
    assign enq_fire = can_enq && !dq.i_squash_vld && !rst;
    assign n_enq    = enq_fire ? CNT_W'(count_one(32'(dq.i_enq_vld))) : '0;

    generate
        for (genvar gi = 0; gi < DEQ_NUM; gi++) begin : g_deq
            assign deq_vld[gi]       = count_q > CNT_W'(gi);
            assign dq.o_deq_data[gi] = mem_q[head_q + PTR_W'(gi)];
        end
    endgenerate

    assign acc_masked = dq.i_deq_accept & deq_vld;

    lead_one_cnt #(.N(DEQ_NUM), .CW(DCNT_W)) u_lead_one_cnt (
        .vec_i (acc_masked),
        .cnt_o (lead_cnt)
    );

    assign n_deq = CNT_W'(lead_cnt);

    always_comb begin
        head_d  = head_q + PTR_W'(n_deq);
        tail_d  = tail_q + PTR_W'(n_enq);
        count_d = count_q + n_enq - n_deq;
        if (dq.i_squash_vld) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int j = 0; j < ENQ_NUM; j++) begin
                if (dq.i_enq_vld[j]) begin
                    mem_q[tail_q + PTR_W'(j)] <= dq.i_enq_data[j];
                end
            end
        end
    end

    assign dq.o_can_enq = can_enq;
    assign dq.o_deq_vld = deq_vld;
    assign dq.o_count   = count_q;

    logic enq_prefix, acc_prefix, acc_subset;
    assign enq_prefix = (dq.i_enq_vld & (dq.i_enq_vld + ENQ_NUM'(1))) == '0;
    assign acc_prefix = (dq.i_deq_accept & (dq.i_deq_accept + DEQ_NUM'(1))) == '0;
    assign acc_subset = (dq.i_deq_accept & ~deq_vld) == '0;

    // A gapped accept is tolerated in hardware (bits past the gap are dropped), so it only warns.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (enq_prefix)
                else $error("int_disp_queue: enqueue mask is not a prefix");
            if (!dq.i_squash_vld) begin
                assert (acc_prefix && acc_subset)
                    else $warning("int_disp_queue: accept mask not a prefix of valid entries");
            end
            assert (count_q <= CNT_W'(DEPTH))
                else $error("int_disp_queue: occupancy above depth");
        end
    end
endmodule

// File: tb/tb_int_disp_queue.sv
// Directed bench for int_disp_queue; the driver queues expected snapshots that a negedge monitor checks.
module tb_int_disp_queue;
    import int_disp_queue_pkg::*;

    localparam int DEPTH = 16;
    localparam int ENQ   = 4;
    localparam int DEQ   = 4;
    localparam int W     = 128;
    localparam int CW    = $clog2(DEPTH+1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int_disp_queue_if #(.DEPTH(DEPTH), .ENQ_NUM(ENQ), .DEQ_NUM(DEQ), .ENTRY_W(W)) dq();

    int_disp_queue #(.DEPTH(DEPTH), .ENQ_NUM(ENQ), .DEQ_NUM(DEQ), .ENTRY_W(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .dq  (dq)
    );

    typedef struct {
        int                       cyc;
        string                    tag;
        logic [CW-1:0]            cnt;
        logic                     can;
        logic [DEQ-1:0]           vld;
        logic [DEQ-1:0][W-1:0]    data;
    } exp_t;

    exp_t       exp_q[$];
    logic [W-1:0] mq[$];
    int         cyc_cnt = 0;
    int         total   = 0;
    int         bad     = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [W-1:0] mk(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Apply one cycle of stimulus, advance the reference queue, queue the expected snapshot.
    task automatic step(input string tag, input logic r, input logic sq,
                        input logic [ENQ-1:0] ev, input logic [7:0] base,
                        input logic [DEQ-1:0] acc);
        exp_t e;
        int   n;
        bit   can;
        rst             = r;
        dq.i_squash_vld = sq;
        dq.i_enq_vld    = ev;
        dq.i_deq_accept = acc;
        for (int j = 0; j < ENQ; j++) dq.i_enq_data[j] = mk(base + 8'(j));
        can = (DEPTH - mq.size()) >= ENQ;
        if (r || sq) begin
            mq.delete();
        end else begin
            n = 0;
            while (n < DEQ && n < mq.size() && acc[n]) n++;
            repeat (n) void'(mq.pop_front());
            if (can) begin
                for (int j = 0; j < ENQ; j++) if (ev[j]) mq.push_back(mk(base + 8'(j)));
            end
        end
        e.cyc = cyc_cnt + 1;
        e.tag = tag;
        e.cnt = CW'(mq.size());
        e.can = (DEPTH - mq.size()) >= ENQ;
        for (int i = 0; i < DEQ; i++) begin
            e.vld[i]  = i < mq.size();
            e.data[i] = e.vld[i] ? mq[i] : '0;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            if (exp_q[0].cyc < cyc_cnt) begin
                exp_t m;
                m = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL missed_%s: got none want check at cyc %0d", m.tag, m.cyc);
            end else if (exp_q[0].cyc == cyc_cnt) begin
                exp_t e;
                e = exp_q.pop_front();
                $display("chk %-10s cyc=%0d cnt=%0d can=%b vld=%b d0=%0h", e.tag, cyc_cnt,
                         dq.o_count, dq.o_can_enq, dq.o_deq_vld, dq.o_deq_data[0][7:0]);
                check({e.tag, "_count"}, W'(dq.o_count), W'(e.cnt));
                check({e.tag, "_can_enq"}, W'(dq.o_can_enq), W'(e.can));
                check({e.tag, "_deq_vld"}, W'(dq.o_deq_vld), W'(e.vld));
                for (int i = 0; i < DEQ; i++) begin
                    if (e.vld[i]) check($sformatf("%s_data%0d", e.tag, i), dq.o_deq_data[i], e.data[i]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        dq.i_squash_vld = 1'b0;
        dq.i_enq_vld    = '0;
        dq.i_deq_accept = '0;
        dq.i_enq_data   = '0;

        step("reset", 1, 0, 4'b0000, 8'h00, 4'b0000);
        step("reset", 1, 0, 4'b0000, 8'h00, 4'b0000);
        step("enq4",  0, 0, 4'b1111, 8'hA0, 4'b0000);
        step("acc2",  0, 0, 4'b0000, 8'h00, 4'b0011);
        step("accgap",0, 0, 4'b0000, 8'h00, 4'b0101);
        step("fill",  0, 0, 4'b1111, 8'hB0, 4'b0000);
        step("fill",  0, 0, 4'b1111, 8'hB4, 4'b0000);
        step("fill",  0, 0, 4'b0111, 8'hB8, 4'b0000);
        step("fill",  0, 0, 4'b1111, 8'hBC, 4'b0000);
        step("fulldrop", 0, 0, 4'b1111, 8'hFF, 4'b0000);
        step("drain", 0, 0, 4'b0000, 8'h00, 4'b1111);
        step("drain", 0, 0, 4'b0000, 8'h00, 4'b1111);
        step("drain", 0, 0, 4'b0000, 8'h00, 4'b1111);
        step("drain", 0, 0, 4'b0000, 8'h00, 4'b0001);
        for (int k = 0; k < 40; k++) begin
            step("wrap", 0, 0, 4'b0011, 8'(8'h10 + 2*k), 4'b0011);
        end
        step("to5",     0, 0, 4'b0011, 8'hC0, 4'b0000);
        step("squash",  0, 1, 4'b1111, 8'hD0, 4'b0001);
        step("postsq",  0, 0, 4'b0001, 8'hC5, 4'b0000);
        step("to9",     0, 0, 4'b1111, 8'hE0, 4'b0000);
        step("to9",     0, 0, 4'b1111, 8'hE4, 4'b0000);
        step("rstmid",  1, 0, 4'b1111, 8'hF0, 4'b0011);
        step("idle",    0, 0, 4'b0000, 8'h00, 4'b0000);

        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_scoreboard: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
